child_cfg_arb: RTL and testbench
================================

Name: child_cfg_arb

Overview:
- Shares the 3-bit `sig_a` configuration input of a `child` instance between NUM_REQ requesters. Round-robin arbitration.
- The winning requester's value is driven onto `sig_a` for a fixed hold window; the idle default applies otherwise.
- Sits in the parent module next to the `child` instance.
- The parent drives `sig_a` through a local `logic` net (connected via template), never through a parent port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 3, width of `sig_a` and of each request data word
- HOLD_CYCLES, 4, cycles a granted value stays on `sig_a` (1..255)
- IDLE_VAL, 3'b101, value on `sig_a_o` when no grant is active

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_i  input  NUM_REQ  per-requester request, level
- data_i  input  NUM_REQ*DATA_W  requester k's value at bits [k*DATA_W +: DATA_W]
- gnt_o  output  NUM_REQ  one-hot, high for the whole hold window of the owner
- done_o  output  NUM_REQ  one-hot, one-cycle pulse in the last hold cycle
- sig_a_o  output  DATA_W  registered value to `child.sig_a`
- busy_o  output  1  high while a grant is active

Behaviour:
- One clock, `clk`. Reset is asynchronous, active-low on `rst_n`.
- Reset values:
  - state = IDLE, `gnt_o` = 0, `done_o` = 0, `busy_o` = 0.
  - `sig_a_o` = IDLE_VAL, hold counter = 0.
  - rr pointer = NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - `sig_a_o` = IDLE_VAL.
  - If `req_i` != 0, pick the first set bit searching upward from (ptr+1) mod NUM_REQ.
  - Register on the next edge: owner, `gnt_o[owner]` = 1, `sig_a_o` = data_i[owner], counter = HOLD_CYCLES-1, `busy_o` = 1. Go to HOLD.
  - Latency: request to grant and to `sig_a_o` is 1 cycle.
- HOLD:
  - `sig_a_o` is frozen at the data latched at grant. Changes on `data_i` are ignored.
  - Counter decrements each cycle.
  - When counter == 0, `done_o[owner]` = 1 for that cycle and ptr <= owner.
  - Next edge, if any `req_i` is set (owner included), arbitrate again from the updated ptr. The new grant starts immediately, with no idle bubble.
  - Next edge with no request: return to IDLE; `sig_a_o` = IDLE_VAL, `gnt_o` = 0, `busy_o` = 0.
- HOLD_CYCLES = 1: grant and done are in the same cycle.
- Dropping `req_i[owner]` mid-hold does not shorten the window; the hold completes.
- Requests from non-owners during HOLD are only sampled at the end-of-hold decision.
- Simultaneous requests: strict rotation, with the last owner lowest priority. A single continuous requester is re-granted back-to-back.
- Reset mid-hold: all outputs return to reset values immediately (async). No done pulse is issued.
- Counter width = $clog2(HOLD_CYCLES+1).
- Invariants: `gnt_o` and `done_o` are always one-hot or zero. `done_o` is a subset of `gnt_o`.

Optional Feature:
- Macro CHILD_CFG_ARB_LOCK_EN.
- Defined:
  - Adds input `lock_i` [NUM_REQ].
  - If `lock_i[owner]` = 1 when the counter reaches 0, the hold restarts: counter = HOLD_CYCLES-1, same owner, and `sig_a_o` reloads from data_i[owner].
  - `done_o` is not pulsed and ptr is not updated. Other requesters wait.
  - Lock is ignored in IDLE.
- Not defined: no `lock_i` port; behaviour exactly as above.

Decomposition:
- Package `child_cfg_pkg`:
  - state enum {IDLE, HOLD}.
  - Default constant CHILD_SIG_A_IDLE = 3'b101.
  - Typedef `sig_a_t` = logic [2:0].
- Sub-module `child_cfg_rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector and `ptr`.
  - Outputs: `valid` and `idx`.
  - Parameterised by NUM_REQ.

Test Plan:
- Reset, no requests for 10 cycles -> `sig_a_o` = 3'b101, `gnt_o` = 0, `busy_o` = 0 throughout.
- `req_i` = 4'b0010, data1 = 3'b011, HOLD_CYCLES = 4 ->
  - `gnt_o` = 4'b0010 from cycle 1 to cycle 4.
  - `sig_a_o` = 3'b011 for cycles 1-4.
  - `done_o[1]` pulses in cycle 4.
  - `sig_a_o` = 3'b101 in cycle 5.
- `req_i` = 4'b1111 held continuously -> grants in order 0,1,2,3,0, each exactly 4 cycles, back-to-back with no IDLE cycle.
- Owner 2 changes data from 3'b110 to 3'b001 and drops req mid-hold -> `sig_a_o` stays 3'b110 to window end; `done_o[2]` still pulses.
- `rst_n` asserted in the 2nd hold cycle -> same-cycle `gnt_o` = 0 and `sig_a_o` = 3'b101. After release, requester 0 wins first.
- With CHILD_CFG_ARB_LOCK_EN: `lock_i[0]` = 1 for 2 windows, `req_i` = 4'b0011 ->
  - Owner 0 for 8 cycles, then `done_o[0]`.
  - Requester 1 is then granted.

Source files
------------

// File: rtl/child_cfg_pkg.sv
// Shared types and constants for the child sig_a configuration arbiter.
package child_cfg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef logic [2:0] sig_a_t;

    localparam sig_a_t CHILD_SIG_A_IDLE = 3'b101;

endpackage

// File: rtl/child_cfg_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1.
module child_cfg_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic               valid,
    output logic [PW-1:0]      idx
);

    int cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/child_cfg_arb.sv
// Round-robin arbiter sharing child.sig_a among NUM_REQ requesters with a fixed hold window.
// Optional macro CHILD_CFG_ARB_LOCK_EN adds lock_i to extend the current owner's window.
module child_cfg_arb
    import child_cfg_pkg::*;
#(
    parameter int                NUM_REQ     = 4,
    parameter int                DATA_W      = 3,
    parameter int                HOLD_CYCLES = 4,
    parameter logic [DATA_W-1:0] IDLE_VAL    = DATA_W'(CHILD_SIG_A_IDLE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
`ifdef CHILD_CFG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock_i,
`endif
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         sig_a_o,
    output logic                      busy_o
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   sig_a_q, sig_a_d;

    logic [PW-1:0]       pick_ptr;
    logic                pick_valid;
    logic [PW-1:0]       pick_idx;
    logic [DATA_W-1:0]   pick_data;
    logic                relock;

`ifdef CHILD_CFG_ARB_LOCK_EN
    assign relock = lock_i[owner_q];
`else
    assign relock = 1'b0;
`endif

    // During HOLD the only decision is at window end, where the old owner becomes the pointer.
    assign pick_ptr  = (state_q == HOLD) ? owner_q : ptr_q;
    assign pick_data = data_i[pick_idx*DATA_W +: DATA_W];

    child_cfg_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req_i),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sig_a_d = sig_a_q;
        done_o  = '0;
        unique case (state_q)
            IDLE: begin
                sig_a_d = IDLE_VAL;
                if (pick_valid) begin
                    state_d = HOLD;
                    owner_d = pick_idx;
                    cnt_d   = CNT_LOAD;
                    sig_a_d = pick_data;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (relock) begin
                    cnt_d   = CNT_LOAD;
                    sig_a_d = data_i[owner_q*DATA_W +: DATA_W];
                end else begin
                    done_o = ONE << owner_q;
                    ptr_d  = owner_q;
                    if (pick_valid) begin
                        owner_d = pick_idx;
                        cnt_d   = CNT_LOAD;
                        sig_a_d = pick_data;
                    end else begin
                        state_d = IDLE;
                        sig_a_d = IDLE_VAL;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sig_a_d = IDLE_VAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= PW'(NUM_REQ - 1);
            cnt_q   <= '0;
            sig_a_q <= IDLE_VAL;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sig_a_q <= sig_a_d;
        end
    end

    assign gnt_o   = (state_q == HOLD) ? (ONE << owner_q) : '0;
    assign busy_o  = (state_q == HOLD);
    assign sig_a_o = sig_a_q;

endmodule

// File: tb/tb_child_cfg_arb.sv
// Scoreboard bench for child_cfg_arb: a window-level reference model predicts each cycle's outputs.
module tb_child_cfg_arb;

    localparam int N  = 4;
    localparam int DW = 3;
    localparam int H  = 4;
`ifdef CHILD_CFG_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_i;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]    lock_i;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    done_o;
    logic [DW-1:0]   sig_a_o;
    logic            busy_o;

    always #5 clk = ~clk;

    child_cfg_arb #(
        .NUM_REQ     (N),
        .DATA_W      (DW),
        .HOLD_CYCLES (H),
        .IDLE_VAL    (3'b101)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .data_i  (data_i),
`ifdef CHILD_CFG_ARB_LOCK_EN
        .lock_i  (lock_i),
`endif
        .gnt_o   (gnt_o),
        .done_o  (done_o),
        .sig_a_o (sig_a_o),
        .busy_o  (busy_o)
    );

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [N-1:0]  done;
        logic [DW-1:0] sig;
        logic          busy;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc_no = 0;

    // Reference model: owner (-1 = nobody), cycles remaining in the window, last owner, latched value.
    int            m_owner;
    int            m_rem;
    int            m_ptr;
    logic [DW-1:0] m_val;

    function automatic logic [N-1:0] lock_eff();
        return LOCK_ON ? lock_i : '0;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_rem   = 0;
        m_ptr   = N - 1;
        m_val   = 3'b101;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        logic [N-1:0] lk;
        lk     = lock_eff();
        e.gnt  = '0;
        e.done = '0;
        e.sig  = 3'b101;
        e.busy = 1'b0;
        if (m_owner >= 0) begin
            e.gnt[m_owner] = 1'b1;
            e.sig          = m_val;
            e.busy         = 1'b1;
            if (m_rem == 1 && !lk[m_owner]) e.done[m_owner] = 1'b1;
        end
        return e;
    endfunction

    function automatic void model_grant();
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req_i[c]) begin
                m_owner = c;
                m_rem   = H;
                m_val   = data_i[c*DW +: DW];
                return;
            end
        end
    endfunction

    function automatic void model_step();
        logic [N-1:0] lk;
        lk = lock_eff();
        if (m_owner < 0) begin
            if (req_i != '0) model_grant();
        end else if (m_rem > 1) begin
            m_rem = m_rem - 1;
        end else if (lk[m_owner]) begin
            m_rem = H;
            m_val = data_i[m_owner*DW +: DW];
        end else begin
            m_ptr   = m_owner;
            m_owner = -1;
            if (req_i != '0) model_grant();
        end
    endfunction

    function automatic logic [N*DW-1:0] mkdata(input int k, input logic [DW-1:0] v);
        logic [N*DW-1:0] d;
        d = N*DW'($urandom);
        d[k*DW +: DW] = v;
        return d;
    endfunction

    // One clock: inputs applied just after the edge, expectation for this cycle queued, model advanced.
    task automatic cyc(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic [N-1:0] l);
        @(posedge clk);
        #1;
        req_i  = r;
        data_i = d;
        lock_i = l;
        q.push_back(model_out());
        model_step();
    endtask

    task automatic check_direct(input string name, input exp_t e);
        exp_t a;
        a = {gnt_o, done_o, sig_a_o, busy_o};
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got gnt=%b done=%b sig=%b busy=%b, want gnt=%b done=%b sig=%b busy=%b",
                      name, a.gnt, a.done, a.sig, a.busy, e.gnt, e.done, e.sig, e.busy);
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        cyc_no++;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {gnt_o, done_o, sig_a_o, busy_o};
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL cycle%0d outputs: got gnt=%b done=%b sig=%b busy=%b, want gnt=%b done=%b sig=%b busy=%b",
                          cyc_no, a.gnt, a.done, a.sig, a.busy, e.gnt, e.done, e.sig, e.busy);
        end
    end

    localparam exp_t RST_EXP = '{gnt: '0, done: '0, sig: 3'b101, busy: 1'b0};

    initial begin
        rst_n  = 1'b0;
        req_i  = '0;
        data_i = '0;
        lock_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_direct("reset_state", RST_EXP);
        rst_n = 1'b1;

        // Idle with no requests
        repeat (10) cyc('0, N*DW'($urandom), '0);

        // Single requester 1, one-cycle request, then idle past window end
        cyc(4'b0010, mkdata(1, 3'b011), '0);
        repeat (7) cyc('0, N*DW'($urandom), '0);

        // All requesting continuously: rotation with no bubbles
        repeat (21) cyc(4'b1111, N*DW'($urandom), '0);
        repeat (5) cyc('0, '0, '0);

        // Owner 2 changes data and drops request mid-hold
        cyc(4'b0100, mkdata(2, 3'b110), '0);
        cyc(4'b0100, mkdata(2, 3'b001), '0);
        repeat (6) cyc('0, mkdata(2, 3'b001), '0);

        // Reset in the second hold cycle
        cyc(4'b0100, mkdata(2, 3'b110), '0);
        cyc(4'b0100, mkdata(2, 3'b110), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_direct("async_reset_mid_hold", RST_EXP);
        model_reset();
        req_i = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) cyc(4'b1111, N*DW'($urandom), '0);
        repeat (4) cyc('0, '0, '0);

        if (LOCK_ON) begin
            // Requester 0 locks for one extra window, then requester 1 takes over
            repeat (5) cyc(4'b0011, N*DW'($urandom), 4'b0001);
            repeat (8) cyc(4'b0011, N*DW'($urandom), 4'b0000);
            repeat (5) cyc('0, '0, '0);
        end

        // Randomised traffic
        for (int i = 0; i < 200; i++) begin
            logic [N-1:0] r;
            logic [N-1:0] l;
            r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            l = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            cyc(r, N*DW'($urandom), l);
        end
        repeat (6) cyc('0, '0, '0);

        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
